// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: imem address/data, redirect request and the IF/ID valid/ready output.
interface instr_fetch_if #(
  parameter int N = 16,
  parameter int R = 5
);
  logic [R-1:0] imem_addr;
  logic [N-1:0] imem_rdata;
  logic         redirect;
  logic [R-1:0] redirect_addr;
  logic         if_ready;
  logic         if_valid;
  logic [N-1:0] if_instr;
  logic [R-1:0] if_pc;
  logic         halted;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, halted,
    input  imem_rdata, redirect, redirect_addr, if_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, halted,
    output imem_rdata, redirect, redirect_addr, if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, registers imem data into IF/ID; 1-cycle latency, holds on !if_ready.
// IFETCH_PERF_EN adds saturating perf_fetch/perf_stall counters.
module instr_fetch #(
  parameter int            N        = 16,
  parameter int            R        = 5,
  parameter logic [R-1:0]  RESET_PC = '0,
  parameter logic [N-1:0]  HALT_OP  = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef IFETCH_PERF_EN
  output logic [15:0]   perf_fetch,
  output logic [15:0]   perf_stall,
`endif
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  state_e       state_q, state_d;
  logic [R-1:0] pc_q, pc_d;
  logic [R-1:0] if_pc_q, if_pc_d;
  logic [N-1:0] instr_q, instr_d;
  logic         vld_q, vld_d;
  logic         load;
  logic         fetch;

  assign load  = (state_q == S_RUN) && (!vld_q || bus.if_ready);
  // a redirect in the same cycle cancels the fetch
  assign fetch = load && !bus.redirect;

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = vld_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.halted    = (state_q == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      if_pc_q <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_pc_q <= if_pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_pc_d = if_pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    if (state_q == S_BOOT) begin
      state_d = S_RUN;
      if (bus.redirect) pc_d = bus.redirect_addr;
    end else if (bus.redirect) begin
      state_d = S_RUN;
      pc_d    = bus.redirect_addr;
      vld_d   = 1'b0;
    end else if (load) begin
      instr_d = bus.imem_rdata;
      if_pc_d = pc_q;
      vld_d   = 1'b1;
      // the halt word is still presented, but the PC parks on it
      if (bus.imem_rdata == HALT_OP) state_d = S_HALT;
      else                           pc_d    = pc_q + R'(1);
    end else if (vld_q && bus.if_ready) begin
      vld_d = 1'b0;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetch_q;
  logic [15:0] perf_stall_q;
  logic        stall;

  assign stall      = (state_q == S_RUN) && vld_q && !bus.if_ready;
  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fetch && (perf_fetch_q != 16'hFFFF)) perf_fetch_q <= perf_fetch_q + 16'd1;
      if (stall && (perf_stall_q != 16'hFFFF)) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end
`else
  logic unused_fetch;
  assign unused_fetch = fetch;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural fetch model checked every cycle plus literal expectations.
module tb_instr_fetch;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem [DEPTH];

  instr_fetch_if #(.N(16), .R(5)) bus ();

`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetch;
  logic [15:0] perf_stall;
`endif

  instr_fetch #(.N(16), .R(5), .RESET_PC(5'd0), .HALT_OP(16'hFFFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef IFETCH_PERF_EN
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = mem[bus.imem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: mode 0 boot, 1 running, 2 halted; PC wraps modulo the memory size
  int          m_mode;
  int          m_pc;
  bit          m_vld;
  logic [15:0] m_instr;
  int          m_ifpc;
  int          m_pf;
  int          m_ps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_pc <= 0; m_vld <= 1'b0; m_instr <= '0; m_ifpc <= 0; m_pf <= 0; m_ps <= 0;
    end else begin
      if (m_mode == 1 && m_vld && !bus.if_ready && m_ps < 65535) m_ps <= m_ps + 1;
      if (m_mode == 0) begin
        m_mode <= 1;
        if (bus.redirect) m_pc <= int'(bus.redirect_addr);
      end else if (bus.redirect) begin
        m_mode <= 1;
        m_pc   <= int'(bus.redirect_addr);
        m_vld  <= 1'b0;
      end else if (m_mode == 1 && (!m_vld || bus.if_ready)) begin
        m_vld   <= 1'b1;
        m_instr <= mem[m_pc];
        m_ifpc  <= m_pc;
        if (m_pf < 65535) m_pf <= m_pf + 1;
        if (mem[m_pc] == 16'hFFFF) m_mode <= 2;
        else                       m_pc   <= (m_pc + 1) % DEPTH;
      end else if (m_vld && bus.if_ready) begin
        m_vld <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_valid", {31'd0, bus.if_valid}, {31'd0, m_vld});
    chk("model_addr", {27'd0, bus.imem_addr}, m_pc);
    chk("model_halted", {31'd0, bus.halted}, {31'd0, m_mode == 2});
    if (m_vld) begin
      chk("model_instr", {16'd0, bus.if_instr}, {16'd0, m_instr});
      chk("model_pc", {27'd0, bus.if_pc}, m_ifpc);
    end
`ifdef IFETCH_PERF_EN
    chk("model_perf_fetch", {16'd0, perf_fetch}, m_pf);
    chk("model_perf_stall", {16'd0, perf_stall}, m_ps);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 16'h1000 + 16'(k);
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_addr = '0;
    bus.if_ready = 1'b1;
    #2;
    chk("reset_valid", {31'd0, bus.if_valid}, 0);
    chk("reset_addr", {27'd0, bus.imem_addr}, 0);
    chk("reset_halted", {31'd0, bus.halted}, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("boot_valid", {31'd0, bus.if_valid}, 0);
    step();
    chk("first_instr", {16'd0, bus.if_instr}, 32'h1000);
    chk("first_pc", {27'd0, bus.if_pc}, 0);
    step();
    chk("second_instr", {16'd0, bus.if_instr}, 32'h1001);
    step();
    chk("third_instr", {16'd0, bus.if_instr}, 32'h1002);
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_instr", {16'd0, bus.if_instr}, 32'h1002);
      chk("bp_pc", {27'd0, bus.if_pc}, 2);
      chk("bp_addr", {27'd0, bus.imem_addr}, 3);
    end
    bus.if_ready = 1'b1;
    step();
    chk("bp_release", {16'd0, bus.if_instr}, 32'h1003);
    chk("bp_release_pc", {27'd0, bus.if_pc}, 3);
    bus.if_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_addr = 5'd20;
    step();
    bus.redirect = 1'b0;
    chk("redir_valid", {31'd0, bus.if_valid}, 0);
    chk("redir_addr", {27'd0, bus.imem_addr}, 20);
    step();
    chk("redir_instr", {16'd0, bus.if_instr}, 32'h1014);
    chk("redir_pc", {27'd0, bus.if_pc}, 20);
    bus.if_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_addr = 5'd30;
    step();
    bus.redirect = 1'b0;
    step(); chk("wrap_pc30", {27'd0, bus.if_pc}, 30);
    step(); chk("wrap_pc31", {27'd0, bus.if_pc}, 31);
    step(); chk("wrap_pc0", {27'd0, bus.if_pc}, 0);
    step(); chk("wrap_pc1", {27'd0, bus.if_pc}, 1);
    mem[4] = 16'hFFFF;
    step(); step(); step();
    chk("halt_instr", {16'd0, bus.if_instr}, 32'hFFFF);
    chk("halt_pc", {27'd0, bus.if_pc}, 4);
    chk("halt_valid", {31'd0, bus.if_valid}, 1);
    chk("halt_flag", {31'd0, bus.halted}, 1);
    step();
    chk("halt_drop", {31'd0, bus.if_valid}, 0);
    chk("halt_addr", {27'd0, bus.imem_addr}, 4);
    step();
    chk("halt_stays", {31'd0, bus.halted}, 1);
    mem[4] = 16'h1004;
    bus.redirect = 1'b1;
    bus.redirect_addr = 5'd0;
    step();
    bus.redirect = 1'b0;
    chk("resume_halted", {31'd0, bus.halted}, 0);
    chk("resume_addr", {27'd0, bus.imem_addr}, 0);
    step();
    chk("resume_instr", {16'd0, bus.if_instr}, 32'h1000);
    for (int i = 0; i < 7; i++) step();
    chk("pre_reset_pc", {27'd0, bus.if_pc}, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", {31'd0, bus.if_valid}, 0);
    chk("midreset_addr", {27'd0, bus.imem_addr}, 0);
`ifdef IFETCH_PERF_EN
    chk("midreset_perf_fetch", {16'd0, perf_fetch}, 0);
    chk("midreset_perf_stall", {16'd0, perf_stall}, 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("reboot_valid", {31'd0, bus.if_valid}, 0);
    step(); step(); step();
    chk("reboot_instr", {16'd0, bus.if_instr}, 32'h1002);
    chk("reboot_pc", {27'd0, bus.if_pc}, 2);
`ifdef IFETCH_PERF_EN
    chk("perf_fetch3", {16'd0, perf_fetch}, 3);
`endif
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
